conv_layer_scheduler: RTL

//  Layer-level sequencer for the conv engine. It walks every output position (col, row) of every

---
 rtl/conv_layer_scheduler_pkg.sv | 25 ++
 rtl/conv_layer_scheduler_if.sv | 40 ++++
 rtl/conv_layer_scheduler_window_counter.sv | 92 +++++++++
 rtl/conv_layer_scheduler.sv | 97 +++++++++
 4 files changed

// File: rtl/conv_layer_scheduler_pkg.sv
// Shared types and derived-size helpers for the conv layer scheduler.
package conv_layer_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ADVANCE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  function automatic int num_windows(input int img_w, input int img_h, input int k, input int nf);
    return nf * out_dim(img_w, k) * out_dim(img_h, k);
  endfunction

  // Counter width that never collapses to zero bits for single-entry dimensions.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Scheduler <-> controller/engine signal bundle; master is the scheduler side.
interface conv_layer_scheduler_if #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 3,
  parameter int NUM_FILT   = 4,
  parameter int ADDR_W     = 10,
  parameter int OUT_ADDR_W = 12
);
  localparam int OW = conv_layer_scheduler_pkg::out_dim(IMG_W, K);
  localparam int OH = conv_layer_scheduler_pkg::out_dim(IMG_H, K);
  localparam int CW = conv_layer_scheduler_pkg::cnt_w(OW);
  localparam int RW = conv_layer_scheduler_pkg::cnt_w(OH);
  localparam int FW = conv_layer_scheduler_pkg::cnt_w(NUM_FILT);

  logic                  start;
  logic                  abort;
  logic                  eng_start;
  logic                  eng_done;
  logic [RW-1:0]         win_row;
  logic [CW-1:0]         win_col;
  logic [FW-1:0]         filt_idx;
  logic [ADDR_W-1:0]     in_base_addr;
  logic [OUT_ADDR_W-1:0] out_addr;
  logic                  busy;
  logic                  layer_done;
  logic                  proto_err;

  modport master (
    input  start, abort, eng_done,
    output eng_start, win_row, win_col, filt_idx, in_base_addr, out_addr,
           busy, layer_done, proto_err
  );

  modport slave (
    output start, abort, eng_done,
    input  eng_start, win_row, win_col, filt_idx, in_base_addr, out_addr,
           busy, layer_done, proto_err
  );
endinterface

// File: rtl/conv_layer_scheduler_window_counter.sv
// Nested col/row/filter counters with multiplier-free window and output addressing.
module conv_layer_scheduler_window_counter
  import conv_layer_scheduler_pkg::*;
#(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 3,
  parameter int NUM_FILT   = 4,
  parameter int ADDR_W     = 10,
  parameter int OUT_ADDR_W = 12,
  localparam int OW = out_dim(IMG_W, K),
  localparam int OH = out_dim(IMG_H, K),
  localparam int CW = cnt_w(OW),
  localparam int RW = cnt_w(OH),
  localparam int FW = cnt_w(NUM_FILT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  step_i,
  output logic [CW-1:0]         col_o,
  output logic [RW-1:0]         row_o,
  output logic [FW-1:0]         filt_o,
  output logic [ADDR_W-1:0]     in_base_o,
  output logic [OUT_ADDR_W-1:0] out_addr_o,
  output logic                  last_o
);
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [FW-1:0]         filt_q, filt_d;
  logic [ADDR_W-1:0]     in_base_q, in_base_d;
  logic [OUT_ADDR_W-1:0] out_addr_q, out_addr_d;
  logic                  col_wrap, row_wrap, filt_wrap;

  assign col_wrap  = (col_q == CW'(OW - 1));
  assign row_wrap  = (row_q == RW'(OH - 1));
  assign filt_wrap = (filt_q == FW'(NUM_FILT - 1));

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    filt_d     = filt_q;
    in_base_d  = in_base_q;
    out_addr_d = out_addr_q;
    if (clear_i) begin
      col_d      = '0;
      row_d      = '0;
      filt_d     = '0;
      in_base_d  = '0;
      out_addr_d = '0;
    end else if (step_i) begin
      out_addr_d = out_addr_q + 1'b1;
      if (!col_wrap) begin
        col_d     = col_q + 1'b1;
        in_base_d = in_base_q + 1'b1;
      end else if (!row_wrap) begin
        // Skipping the K-1 pixels right of the last window lands on the next row start.
        col_d     = '0;
        row_d     = row_q + 1'b1;
        in_base_d = in_base_q + ADDR_W'(K);
      end else begin
        col_d     = '0;
        row_d     = '0;
        in_base_d = '0;
        filt_d    = filt_wrap ? '0 : filt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      filt_q     <= '0;
      in_base_q  <= '0;
      out_addr_q <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      filt_q     <= filt_d;
      in_base_q  <= in_base_d;
      out_addr_q <= out_addr_d;
    end
  end

  assign col_o      = col_q;
  assign row_o      = row_q;
  assign filt_o     = filt_q;
  assign in_base_o  = in_base_q;
  assign out_addr_o = out_addr_q;
  assign last_o     = col_wrap && row_wrap && filt_wrap;
endmodule

// File: rtl/conv_layer_scheduler.sv
// Layer sequencer: issues one engine start per output window of every filter.
module conv_layer_scheduler
  import conv_layer_scheduler_pkg::*;
#(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 3,
  parameter int NUM_FILT   = 4,
  parameter int ADDR_W     = 10,
  parameter int OUT_ADDR_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_layer_scheduler_if.master bus
);
  localparam int OW = out_dim(IMG_W, K);
  localparam int OH = out_dim(IMG_H, K);
  localparam int CW = cnt_w(OW);
  localparam int RW = cnt_w(OH);
  localparam int FW = cnt_w(NUM_FILT);

  state_e state_q, state_d;
  logic   eng_start_q, eng_start_d;
  logic   busy_q, busy_d;
  logic   layer_done_q, layer_done_d;
  logic   proto_err_q, proto_err_d;
  logic   clear, step, last;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [FW-1:0]         filt;
  logic [ADDR_W-1:0]     in_base;
  logic [OUT_ADDR_W-1:0] out_addr;

  assign clear = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign step  = (state_q == ST_ADVANCE) && !bus.abort;

  conv_layer_scheduler_window_counter #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .NUM_FILT(NUM_FILT),
    .ADDR_W(ADDR_W), .OUT_ADDR_W(OUT_ADDR_W)
  ) u_cnt (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .step_i(step),
    .col_o(col), .row_o(row), .filt_o(filt),
    .in_base_o(in_base), .out_addr_o(out_addr), .last_o(last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      eng_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      layer_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      eng_start_q  <= eng_start_d;
      busy_q       <= busy_d;
      layer_done_q <= layer_done_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Abort beats everything outside IDLE, including a coincident eng_done.
  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (bus.start && !bus.abort) state_d = ST_ISSUE;
        ST_ISSUE:   state_d = ST_WAIT;
        ST_WAIT:    if (bus.eng_done) state_d = ST_ADVANCE;
        ST_ADVANCE: state_d = last ? ST_DONE : ST_ISSUE;
        ST_DONE:    state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_comb begin
    eng_start_d  = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE);
    layer_done_d = (state_d == ST_DONE);
    proto_err_d  = (clear ? 1'b0 : proto_err_q) | (bus.eng_done && (state_q != ST_WAIT));
  end

  assign bus.eng_start    = eng_start_q;
  assign bus.busy         = busy_q;
  assign bus.layer_done   = layer_done_q;
  assign bus.proto_err    = proto_err_q;
  assign bus.win_col      = col;
  assign bus.win_row      = row;
  assign bus.filt_idx     = filt;
  assign bus.in_base_addr = in_base;
  assign bus.out_addr     = out_addr;
endmodule
